// File: rtl/sobel_pkg.sv
// Shared constants, agent state encoding and arithmetic helpers
// for the Sobel edge engine.
package sobel_pkg;

  localparam int PX_W   = 15;
  localparam int THR_W  = 14;
  localparam int GRAD_W = 18;
  localparam int MAG_W  = 19;

  localparam logic [PX_W-1:0] PX_MAX = 15'h7FFF;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GRANT,
    REL
  } agent_state_e;

  // Unsigned pixel widened into the signed gradient domain
  function automatic logic signed [GRAD_W-1:0] px_ext(
    input logic [PX_W-1:0] p
  );
    return $signed({{(GRAD_W-PX_W){1'b0}}, p});
  endfunction

  // Absolute value; the gradient range never reaches the minimum code
  function automatic logic [GRAD_W-1:0] grad_abs(
    input logic signed [GRAD_W-1:0] g
  );
    return g[GRAD_W-1] ? GRAD_W'(-g) : GRAD_W'(g);
  endfunction

endpackage

// File: rtl/buffer_handshake_agent.sv
// Req/ack handshake agent claiming one shared frame buffer.
// State, request and grant are all registered.
import sobel_pkg::*;

module buffer_handshake_agent (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic ack_i,
  output logic rq_o,
  output logic granted_o
);

  agent_state_e state_q;
  logic         rq_q;
  logic         granted_q;

  // Request/grant sequencing; losing enable in REQ beats a late ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rq_q      <= 1'b0;
      granted_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable_i) begin
            state_q <= REQ;
            rq_q    <= 1'b1;
          end
        end
        REQ: begin
          if (!enable_i) begin
            state_q <= IDLE;
            rq_q    <= 1'b0;
          end else if (ack_i) begin
            state_q   <= GRANT;
            granted_q <= 1'b1;
          end
        end
        GRANT: begin
          if (!enable_i) begin
            state_q   <= REL;
            rq_q      <= 1'b0;
            granted_q <= 1'b0;
          end
        end
        REL: begin
          if (!ack_i) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          rq_q      <= 1'b0;
          granted_q <= 1'b0;
        end
      endcase
    end
  end

  assign rq_o      = rq_q;
  assign granted_o = granted_q;

endmodule

// File: rtl/sobel_edge_engine.sv
// Two-stage Sobel gradient magnitude engine behind two buffer agents.
// Define SOBEL_BINARIZE_EN for thresholded (binary) edge output.
import sobel_pkg::*;

module sobel_edge_engine (
  input  logic             sobel_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             ack_read,
  output logic             rq_read,
  output logic             reading,
  input  logic             ack_write,
  output logic             rq_write,
  output logic             writing,
  output logic             ready,
  input  logic             in_valid,
  input  logic [PX_W-1:0]  px_0,
  input  logic [PX_W-1:0]  px_1,
  input  logic [PX_W-1:0]  px_2,
  input  logic [PX_W-1:0]  px_3,
  input  logic [PX_W-1:0]  px_5,
  input  logic [PX_W-1:0]  px_6,
  input  logic [PX_W-1:0]  px_7,
  input  logic [PX_W-1:0]  px_8,
  input  logic [THR_W-1:0] threshold,
  output logic             out_valid,
  output logic [PX_W-1:0]  out_px
);

  buffer_handshake_agent u_rd_agent (
    .clk       (sobel_clk),
    .rst_n     (reset),
    .enable_i  (enable),
    .ack_i     (ack_read),
    .rq_o      (rq_read),
    .granted_o (reading)
  );

  buffer_handshake_agent u_wr_agent (
    .clk       (sobel_clk),
    .rst_n     (reset),
    .enable_i  (enable),
    .ack_i     (ack_write),
    .rq_o      (rq_write),
    .granted_o (writing)
  );

  assign ready = reading & writing;

  logic                     accept;
  logic signed [GRAD_W-1:0] gx_d, gy_d;
  logic signed [GRAD_W-1:0] gx_q, gy_q;
  logic                     v1_q;
  logic [MAG_W-1:0]         mag;
  logic [PX_W-1:0]          res_d;
  logic                     out_valid_q;
  logic [PX_W-1:0]          out_px_q;

  assign accept = in_valid & ready;

  // Stage 1 kernels: Gx right minus left, Gy bottom minus top
  always_comb begin
    gx_d = (px_ext(px_2) + (px_ext(px_5) <<< 1) + px_ext(px_8))
         - (px_ext(px_0) + (px_ext(px_3) <<< 1) + px_ext(px_6));
    gy_d = (px_ext(px_6) + (px_ext(px_7) <<< 1) + px_ext(px_8))
         - (px_ext(px_0) + (px_ext(px_1) <<< 1) + px_ext(px_2));
  end

  // Stage 2 L1 magnitude and output shaping
  always_comb begin
    mag = {1'b0, grad_abs(gx_q)} + {1'b0, grad_abs(gy_q)};
`ifdef SOBEL_BINARIZE_EN
    res_d = (mag >= MAG_W'(threshold)) ? PX_MAX : '0;
`else
    res_d = (mag > MAG_W'(PX_MAX)) ? PX_MAX : mag[PX_W-1:0];
`endif
  end

`ifndef SOBEL_BINARIZE_EN
  logic unused_threshold;
  assign unused_threshold = ^threshold;
`endif

  // Pipeline registers; valid advances every cycle regardless of ready
  always_ff @(posedge sobel_clk or negedge reset) begin
    if (!reset) begin
      v1_q        <= 1'b0;
      gx_q        <= '0;
      gy_q        <= '0;
      out_valid_q <= 1'b0;
      out_px_q    <= '0;
    end else begin
      v1_q        <= accept;
      out_valid_q <= v1_q;
      if (accept) begin
        gx_q <= gx_d;
        gy_q <= gy_d;
      end
      if (v1_q) begin
        out_px_q <= res_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_px    = out_px_q;

endmodule

// File: tb/tb_sobel_edge_engine.sv
// Directed self-checking bench for sobel_edge_engine.
// Expectations are hand-computed Sobel results.
module tb_sobel_edge_engine;

  logic        clk;
  logic        rst_n;
  logic        enable, ack_read, ack_write;
  logic        rq_read, reading, rq_write, writing, ready;
  logic        in_valid;
  logic [14:0] p0, p1, p2, p3, p5, p6, p7, p8;
  logic [13:0] threshold;
  logic        out_valid;
  logic [14:0] out_px;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef SOBEL_BINARIZE_EN
  localparam logic [14:0] E_VERT = 15'd32767;
  localparam logic [14:0] E_A    = 15'd0;
  localparam logic [14:0] E_B    = 15'd32767;
  localparam logic [14:0] E_C    = 15'd32767;
`else
  localparam logic [14:0] E_VERT = 15'd4000;
  localparam logic [14:0] E_A    = 15'd40;
  localparam logic [14:0] E_B    = 15'd200;
  localparam logic [14:0] E_C    = 15'd1200;
`endif

  sobel_edge_engine dut (
    .sobel_clk (clk),
    .reset     (rst_n),
    .enable    (enable),
    .ack_read  (ack_read),
    .rq_read   (rq_read),
    .reading   (reading),
    .ack_write (ack_write),
    .rq_write  (rq_write),
    .writing   (writing),
    .ready     (ready),
    .in_valid  (in_valid),
    .px_0      (p0),
    .px_1      (p1),
    .px_2      (p2),
    .px_3      (p3),
    .px_5      (p5),
    .px_6      (p6),
    .px_7      (p7),
    .px_8      (p8),
    .threshold (threshold),
    .out_valid (out_valid),
    .out_px    (out_px)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic win(input logic [14:0] a0, a1, a2, a3,
                     input logic [14:0] a5, a6, a7, a8);
    p0 = a0; p1 = a1; p2 = a2; p3 = a3;
    p5 = a5; p6 = a6; p7 = a7; p8 = a8;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; ack_read = 1'b0; ack_write = 1'b0;
    in_valid = 1'b0; threshold = 14'd150;
    win(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("rst_rq_read", rq_read, 0);
    chk("rst_rq_write", rq_write, 0);
    chk("rst_reading", reading, 0);
    chk("rst_ready", ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_px", out_px, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_rq", rq_read, 0);

    // handshake bring-up
    enable = 1'b1;
    tick();
    chk("req_rq_read", rq_read, 1);
    chk("req_rq_write", rq_write, 1);
    chk("req_reading", reading, 0);
    ack_read = 1'b1;
    tick();
    chk("gr_reading", reading, 1);
    chk("gr_writing0", writing, 0);
    chk("gr_ready0", ready, 0);
    ack_write = 1'b1;
    tick();
    chk("gr_writing", writing, 1);
    chk("gr_ready", ready, 1);

    // flat window, latency
    win(100, 100, 100, 100, 100, 100, 100, 100);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("flat_lat1", out_valid, 0);
    tick();
    chk("flat_valid", out_valid, 1);
    chk("flat_px", out_px, 0);
    tick();
    chk("flat_pulse", out_valid, 0);

    // vertical edge
    win(0, 500, 1000, 0, 1000, 0, 500, 1000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("vert_valid", out_valid, 1);
    chk("vert_px", out_px, E_VERT);
    tick();
    chk("vert_pulse", out_valid, 0);
    chk("vert_hold", out_px, E_VERT);

    // saturation
    win(0, 0, 32767, 0, 32767, 0, 0, 32767);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("sat_valid", out_valid, 1);
    chk("sat_px", out_px, 32767);

    // back-to-back A, B, C
    win(0, 0, 10, 0, 10, 0, 0, 10);
    in_valid = 1'b1;
    tick();
    win(0, 0, 0, 0, 0, 50, 50, 50);
    chk("b2b_gap", out_valid, 0);
    tick();
    win(300, 0, 0, 300, 0, 300, 0, 0);
    chk("b2b_a_v", out_valid, 1);
    chk("b2b_a_px", out_px, E_A);
    tick();
    in_valid = 1'b0;
    chk("b2b_b_v", out_valid, 1);
    chk("b2b_b_px", out_px, E_B);
    tick();
    chk("b2b_c_v", out_valid, 1);
    chk("b2b_c_px", out_px, E_C);
    tick();
    chk("b2b_end", out_valid, 0);

    // ready falls while a window is in flight
    win(0, 0, 0, 0, 0, 50, 50, 50);
    in_valid = 1'b1;
    enable   = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("drop_rq", rq_read, 0);
    chk("drop_reading", reading, 0);
    chk("drop_ready", ready, 0);
    tick();
    chk("drop_emit_v", out_valid, 1);
    chk("drop_emit_px", out_px, E_B);

    // in_valid ignored while not ready
    win(0, 0, 0, 0, 0, 0, 0, 900);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nrdy_ignored", out_valid, 0);
    end
    in_valid = 1'b0;
    tick();
    chk("nrdy_late", out_valid, 0);
    chk("nrdy_px_hold", out_px, E_B);

    // REL waits for ack to fall
    enable = 1'b1;
    tick();
    chk("rel_hold_rq", rq_read, 0);
    ack_read  = 1'b0;
    ack_write = 1'b0;
    tick();
    chk("rel_to_idle", rq_read, 0);
    tick();
    chk("idle_to_req_r", rq_read, 1);
    chk("idle_to_req_w", rq_write, 1);

    // ack and enable drop together in REQ
    enable    = 1'b0;
    ack_read  = 1'b1;
    ack_write = 1'b1;
    tick();
    chk("req_drop_rq", rq_read, 0);
    chk("req_drop_gr", reading, 0);
    enable = 1'b1;
    tick();
    chk("rereq_rq", rq_read, 1);
    chk("rereq_gr", reading, 0);
    tick();
    chk("regrant_ready", ready, 1);

    // ack falling in GRANT is ignored
    ack_read = 1'b0;
    tick();
    chk("ackdrop_reading", reading, 1);
    chk("ackdrop_rq", rq_read, 1);
    ack_read = 1'b1;

    // async reset mid-frame
    win(0, 500, 1000, 0, 1000, 0, 500, 1000);
    in_valid = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_px", out_px, 0);
    chk("arst_rq_read", rq_read, 0);
    chk("arst_reading", reading, 0);
    chk("arst_ready", ready, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("post_rst_v1", out_valid, 0);
    chk("post_rst_req", rq_read, 1);
    chk("post_rst_gr", reading, 0);
    tick();
    chk("post_rst_v2", out_valid, 0);
    chk("post_rst_px", out_px, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
